// File: rtl/exec_pkg.sv
// Shared definitions for the execute pipe: uop encodings, flag bit positions
// and the predicates that decide which uops are legal and which write back.
package exec_pkg;

    typedef logic [4:0] uop_t;

    localparam uop_t UOP_ADD = 5'b00001;
    localparam uop_t UOP_SUB = 5'b00010;
    localparam uop_t UOP_AND = 5'b00011;
    localparam uop_t UOP_ORR = 5'b00100;
    localparam uop_t UOP_EOR = 5'b00101;
    localparam uop_t UOP_MOV = 5'b00110;
    localparam uop_t UOP_CMP = 5'b00111;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    function automatic logic uop_is_valid(input uop_t uop);
        return (uop >= UOP_ADD) && (uop <= UOP_CMP);
    endfunction

    function automatic logic writes_back(input uop_t uop);
        return uop_is_valid(uop) && (uop != UOP_CMP);
    endfunction

endpackage

// File: rtl/exec_pipe_if.sv
// Issue, external-load and result/flags signals of the execute pipe.
// The master drives micro-ops and consumes results; the slave is the pipe.
interface exec_pipe_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    import exec_pkg::*;

    localparam int SW = $clog2(NREGS);

    logic             in_valid;
    logic             in_ready;
    uop_t             in_uop;
    logic [SW-1:0]    in_sel_p0;
    logic [SW-1:0]    in_sel_p1;
    logic [SW-1:0]    in_sel_dst;
    logic             in_use_imm;
    logic [WIDTH-1:0] in_imm;
    logic             in_set_flags;

    logic             wr_valid;
    logic [SW-1:0]    wr_sel;
    logic [WIDTH-1:0] wr_data;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [SW-1:0]    out_dst;
    logic [3:0]       flags_out;

    modport master (
        output in_valid, in_uop, in_sel_p0, in_sel_p1, in_sel_dst,
               in_use_imm, in_imm, in_set_flags,
               wr_valid, wr_sel, wr_data, out_ready,
        input  in_ready, out_valid, out_result, out_dst, flags_out
    );

    modport slave (
        input  in_valid, in_uop, in_sel_p0, in_sel_p1, in_sel_dst,
               in_use_imm, in_imm, in_set_flags,
               wr_valid, wr_sel, wr_data, out_ready,
        output in_ready, out_valid, out_result, out_dst, flags_out
    );

endinterface

// File: rtl/exec_alu.sv
// Combinational ALU: result plus next flags. Unknown uops give 0 and keep flags;
// logical ops and MOV touch only Z/N.
module exec_alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  uop_t             uop,
    input  logic [3:0]       flags_in,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_next
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Operation select and flag generation
    always_comb begin
        sum_s      = {1'b0, lhs} + {1'b0, rhs};
        diff_s     = {1'b0, lhs} - {1'b0, rhs};
        result     = {WIDTH{1'b0}};
        flags_next = flags_in;
        case (uop)
            UOP_ADD: begin
                result             = sum_s[WIDTH-1:0];
                flags_next[FLAG_C] = sum_s[WIDTH];
                flags_next[FLAG_V] = (lhs[WIDTH-1] == rhs[WIDTH-1]) &&
                                     (sum_s[WIDTH-1] != lhs[WIDTH-1]);
            end
            UOP_SUB, UOP_CMP: begin
                // diff_s[WIDTH] is the borrow, so carry is its inverse
                result             = diff_s[WIDTH-1:0];
                flags_next[FLAG_C] = ~diff_s[WIDTH];
                flags_next[FLAG_V] = (lhs[WIDTH-1] != rhs[WIDTH-1]) &&
                                     (diff_s[WIDTH-1] != lhs[WIDTH-1]);
            end
            UOP_AND: result = lhs & rhs;
            UOP_ORR: result = lhs | rhs;
            UOP_EOR: result = lhs ^ rhs;
            UOP_MOV: result = rhs;
            default: result = {WIDTH{1'b0}};
        endcase
        if (uop_is_valid(uop)) begin
            flags_next[FLAG_Z] = (result == {WIDTH{1'b0}});
            flags_next[FLAG_N] = result[WIDTH-1];
        end else begin
            flags_next = flags_in;
        end
    end

endmodule

// File: rtl/exec_pipe.sv
// Two-stage execute pipe: S1 holds captured operands (forwarded from the S1 result
// on RAW), S2 holds the result while the register file and flags update on advance.
module exec_pipe
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    exec_pipe_if.slave bus
);

    localparam int SW = $clog2(NREGS);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic             s1_valid_q, s1_valid_d;
    uop_t             s1_uop_q, s1_uop_d;
    logic [SW-1:0]    s1_dst_q, s1_dst_d;
    logic             s1_set_flags_q, s1_set_flags_d;
    logic [WIDTH-1:0] s1_lhs_q, s1_lhs_d;
    logic [WIDTH-1:0] s1_rhs_q, s1_rhs_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic [SW-1:0]    s2_dst_q, s2_dst_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] alu_result_s;
    logic [3:0]       alu_flags_s;
    logic             s1_adv_s;
    logic             s1_fwd_s;
    logic             s1_wb_s;
    logic             accept_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;

    exec_alu #(.WIDTH(WIDTH)) u_alu (
        .lhs        (s1_lhs_q),
        .rhs        (s1_rhs_q),
        .uop        (s1_uop_q),
        .flags_in   (flags_q),
        .result     (alu_result_s),
        .flags_next (alu_flags_s)
    );

    assign s1_adv_s     = s1_valid_q && (!s2_valid_q || bus.out_ready);
    assign s1_fwd_s     = s1_valid_q && writes_back(s1_uop_q);
    assign s1_wb_s      = s1_adv_s && writes_back(s1_uop_q);
    assign bus.in_ready = reset_n && (!s1_valid_q || s1_adv_s);
    assign accept_s     = bus.in_valid && bus.in_ready;

    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_dst    = s2_dst_q;
    assign bus.flags_out  = flags_q;

    // Operand fetch with forwarding from the op currently in S1
    always_comb begin
        op_a_s = regs_q[bus.in_sel_p0];
        op_b_s = regs_q[bus.in_sel_p1];
        if (s1_fwd_s && (s1_dst_q == bus.in_sel_p0)) begin
            op_a_s = alu_result_s;
        end else begin
            op_a_s = regs_q[bus.in_sel_p0];
        end
        if (bus.in_use_imm) begin
            op_b_s = bus.in_imm;
        end else if (s1_fwd_s && (s1_dst_q == bus.in_sel_p1)) begin
            op_b_s = alu_result_s;
        end else begin
            op_b_s = regs_q[bus.in_sel_p1];
        end
    end

    // Stage next-state and flags update
    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_uop_d       = s1_uop_q;
        s1_dst_d       = s1_dst_q;
        s1_set_flags_d = s1_set_flags_q;
        s1_lhs_d       = s1_lhs_q;
        s1_rhs_d       = s1_rhs_q;
        s2_valid_d     = s2_valid_q;
        s2_result_d    = s2_result_q;
        s2_dst_d       = s2_dst_q;
        flags_d        = flags_q;
        if (accept_s) begin
            s1_valid_d     = 1'b1;
            s1_uop_d       = bus.in_uop;
            s1_dst_d       = bus.in_sel_dst;
            s1_set_flags_d = bus.in_set_flags;
            s1_lhs_d       = op_a_s;
            s1_rhs_d       = op_b_s;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s1_adv_s) begin
            s2_valid_d  = 1'b1;
            s2_result_d = alu_result_s;
            s2_dst_d    = s1_dst_q;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (s1_adv_s && s1_set_flags_q) begin
            flags_d = alu_flags_s;
        end else begin
            flags_d = flags_q;
        end
    end

    // Register file next-state: pipeline writeback beats the external load
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (s1_wb_s && (s1_dst_q == SW'(i))) begin
                regs_d[i] = alu_result_s;
            end else if (bus.wr_valid && (bus.wr_sel == SW'(i))) begin
                regs_d[i] = bus.wr_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
            s1_valid_q     <= 1'b0;
            s1_uop_q       <= 5'b00000;
            s1_dst_q       <= {SW{1'b0}};
            s1_set_flags_q <= 1'b0;
            s1_lhs_q       <= {WIDTH{1'b0}};
            s1_rhs_q       <= {WIDTH{1'b0}};
            s2_valid_q     <= 1'b0;
            s2_result_q    <= {WIDTH{1'b0}};
            s2_dst_q       <= {SW{1'b0}};
            flags_q        <= 4'b0000;
        end else begin
            regs_q         <= regs_d;
            s1_valid_q     <= s1_valid_d;
            s1_uop_q       <= s1_uop_d;
            s1_dst_q       <= s1_dst_d;
            s1_set_flags_q <= s1_set_flags_d;
            s1_lhs_q       <= s1_lhs_d;
            s1_rhs_q       <= s1_rhs_d;
            s2_valid_q     <= s2_valid_d;
            s2_result_q    <= s2_result_d;
            s2_dst_q       <= s2_dst_d;
            flags_q        <= flags_d;
        end
    end

endmodule

// File: tb/tb_exec_pipe.sv
// Bench for exec_pipe: directed scenarios plus randomized ops against an
// architectural reference model, checked through a scoreboard queue.
module tb_exec_pipe;
    import exec_pkg::*;

    typedef struct {
        logic [4:0]  uop;
        logic [3:0]  p0;
        logic [3:0]  p1;
        logic [3:0]  dst;
        logic        use_imm;
        logic [31:0] imm;
        logic        sf;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  dst;
        logic [3:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_out = 0;
    logic bp_mode = 1'b0;
    logic forced_ready = 1'b1;

    logic [31:0] m_regs [16];
    logic [3:0]  m_flags;
    exp_t        exp_q [$];
    logic [31:0] got_q [$];
    int          out_cyc [$];

    exec_pipe_if #(.WIDTH(32), .NREGS(16)) bus ();

    exec_pipe #(.WIDTH(32), .NREGS(16)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    function automatic op_t mk_op(input logic [4:0] uop, input logic [3:0] p0, input logic [3:0] p1,
                                  input logic [3:0] dst, input logic use_imm, input logic [31:0] imm,
                                  input logic sf);
        op_t o;
        o.uop = uop; o.p0 = p0; o.p1 = p1; o.dst = dst;
        o.use_imm = use_imm; o.imm = imm; o.sf = sf;
        return o;
    endfunction

    // Architectural model: executes ops in acceptance order on its own state
    task automatic model_accept(input op_t op);
        logic [31:0] a, b, r;
        logic [3:0]  f;
        longint      s;
        logic        valid;
        exp_t        e;
        a = m_regs[op.p0];
        b = op.use_imm ? op.imm : m_regs[op.p1];
        r = 32'h0;
        f = m_flags;
        valid = (op.uop >= 5'd1) && (op.uop <= 5'd7);
        case (op.uop)
            5'd1: begin
                r = a + b;
                f[2] = (longint'(a) + longint'(b)) > 64'h0000_0000_FFFF_FFFF;
                s = longint'($signed(a)) + longint'($signed(b));
                f[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'd2, 5'd7: begin
                r = a - b;
                f[2] = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                f[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'd3: r = a & b;
            5'd4: r = a | b;
            5'd5: r = a ^ b;
            5'd6: r = b;
            default: r = 32'h0;
        endcase
        f[3] = (r == 32'h0);
        f[1] = r[31];
        if (valid && op.sf) m_flags = f;
        if (valid && op.uop != 5'd7) m_regs[op.dst] = r;
        e.res = r; e.dst = op.dst; e.flags = m_flags;
        exp_q.push_back(e);
    endtask

    task automatic drive(input op_t op);
        bus.in_uop = op.uop; bus.in_sel_p0 = op.p0; bus.in_sel_p1 = op.p1;
        bus.in_sel_dst = op.dst; bus.in_use_imm = op.use_imm;
        bus.in_imm = op.imm; bus.in_set_flags = op.sf;
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic issue(input op_t op, output int waits);
        drive(op);
        bus.in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (bus.in_ready) begin
            model_accept(op);
        end else begin
            checks++; errors++;
            $display("FAIL issue_timeout in_ready=0 required=1");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic ext_write(input logic [3:0] sel, input logic [31:0] data);
        bus.wr_valid = 1'b1; bus.wr_sel = sel; bus.wr_data = data;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        m_regs[sel] = data;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_flags = 4'b0000;
        exp_q.delete();
    endtask

    // Result monitor: pops the scoreboard whenever a result is consumed
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output got=%h required=none", bus.out_result);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", bus.out_result, e.res);
                    check("sb_dst", 32'(bus.out_dst), 32'(e.dst));
                    check("sb_flags", 32'(bus.flags_out), 32'(e.flags));
                end
                got_q.push_back(bus.out_result);
                out_cyc.push_back(cyc);
                n_out++;
            end
        end
    end

    // Result-side ready: random in bp_mode, else directed value
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            bus.out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : forced_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   w, w2, idx, n0, t;
        op_t  op;
        op_t  bp_ops [3];

        bus.in_valid = 1'b0; bus.wr_valid = 1'b0; bus.wr_sel = 4'h0; bus.wr_data = 32'h0;
        drive(mk_op(5'd0, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0));
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_flags", 32'(bus.flags_out), 32'h0);
        check("rst_out_result", bus.out_result, 32'h0);
        check("rst_out_dst", 32'(bus.out_dst), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        ext_write(4'd0, 32'd2);
        ext_write(4'd1, 32'd1);
        issue(mk_op(UOP_SUB, 4'd1, 4'd0, 4'd2, 1'b0, 32'h0, 1'b1), w);
        drain();
        check("sub_flags", 32'(bus.flags_out), 32'(4'b0010));
        check("sub_result", got_q[$], 32'hFFFF_FFFF);

        issue(mk_op(UOP_ADD, 4'd1, 4'd1, 4'd3, 1'b0, 32'h0, 1'b0), w);
        issue(mk_op(UOP_ADD, 4'd3, 4'd3, 4'd4, 1'b0, 32'h0, 1'b0), w2);
        drain();
        check("fwd_in_ready", 32'(w2), 32'h0);
        check("fwd_first", got_q[$-1], 32'd2);
        check("fwd_second", got_q[$], 32'd4);
        check("fwd_back_to_back", 32'(out_cyc[$] - out_cyc[$-1]), 32'd1);

        ext_write(4'd7, 32'h55);
        issue(mk_op(UOP_CMP, 4'd0, 4'd0, 4'd7, 1'b1, 32'd2, 1'b1), w);
        drain();
        check("cmp_flags", 32'(bus.flags_out), 32'(4'b1100));
        check("cmp_result", got_q[$], 32'h0);
        issue(mk_op(UOP_MOV, 4'd7, 4'd7, 4'd7, 1'b0, 32'h0, 1'b0), w);
        drain();
        check("cmp_no_writeback", got_q[$], 32'h55);

        bp_ops[0] = mk_op(UOP_ADD, 4'd1, 4'd0, 4'd10, 1'b0, 32'h0, 1'b0);
        bp_ops[1] = mk_op(UOP_SUB, 4'd10, 4'd1, 4'd11, 1'b0, 32'h0, 1'b1);
        bp_ops[2] = mk_op(UOP_EOR, 4'd11, 4'd0, 4'd12, 1'b0, 32'h0, 1'b1);
        forced_ready = 1'b0;
        n0 = n_out;
        idx = 0;
        drive(bp_ops[0]);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.in_ready && idx < 3) begin model_accept(bp_ops[idx]); idx++; end
            @(posedge clk); #1;
            if (idx < 3) drive(bp_ops[idx]); else bus.in_valid = 1'b0;
        end
        check("bp_accepts_stalled", 32'(idx), 32'd2);
        forced_ready = 1'b1;
        t = 0;
        while (idx < 3 && t < 50) begin
            @(negedge clk);
            if (bus.in_ready) begin model_accept(bp_ops[idx]); idx++; end
            @(posedge clk); #1;
            if (idx < 3) drive(bp_ops[idx]);
            t++;
        end
        bus.in_valid = 1'b0;
        check("bp_all_accepted", 32'(idx), 32'd3);
        drain();
        check("bp_output_count", 32'(n_out - n0), 32'd3);

        issue(mk_op(UOP_MOV, 4'd0, 4'd0, 4'd5, 1'b1, 32'd7, 1'b0), w);
        bus.wr_valid = 1'b1; bus.wr_sel = 4'd5; bus.wr_data = 32'h99;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        issue(mk_op(UOP_MOV, 4'd5, 4'd5, 4'd5, 1'b0, 32'h0, 1'b0), w);
        drain();
        check("collision_r5", got_q[$], 32'd7);

        forced_ready = 1'b0;
        issue(mk_op(UOP_SUB, 4'd0, 4'd0, 4'd8, 1'b1, 32'd5, 1'b1), w);
        issue(mk_op(UOP_ADD, 4'd0, 4'd1, 4'd9, 1'b0, 32'h0, 1'b0), w);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_flags", 32'(bus.flags_out), 32'h0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'h0);
        check("midrst_out_result", bus.out_result, 32'h0);
        model_reset();
        forced_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            issue(mk_op(UOP_MOV, 4'(i), 4'(i), 4'(i), 1'b0, 32'h0, 1'b0), w);
        end
        drain();
        check("midrst_r5_zero", got_q[$-10], 32'h0);

        bp_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (n % 40 == 39) begin
                drain();
                ext_write(4'($urandom_range(0, 15)), $urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            op = mk_op(5'($urandom_range(0, 9)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                       1'($urandom_range(0, 1)));
            issue(op, w);
        end
        drain();
        bp_mode = 1'b0;
        @(posedge clk); #1;
        check("final_flags", 32'(bus.flags_out), 32'(m_flags));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
